// File: rtl/morse_word_buffer.sv
// Per-player morse word buffer: builds letters from dot/line strobes, packs them into a word, hands the word off with valid/ack.
// Optional BACKSPACE_EN adds del_input: it removes the newest symbol, or pops the last committed letter back for editing.
module morse_word_buffer #(
    parameter int MAX_SYMBOLS = 5,
    parameter int LETTERS     = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   ld_dot,
    input  logic                                   ld_line,
    input  logic                                   next_input,
    input  logic                                   done_input,
`ifdef BACKSPACE_EN
    input  logic                                   del_input,
`endif
    input  logic                                   word_ack,
    output logic [2*MAX_SYMBOLS-1:0]               letter_value,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0]       letter_count,
    output logic [LETTERS*2*MAX_SYMBOLS-1:0]       word_data,
    output logic [$clog2(LETTERS+1)-1:0]           word_len,
    output logic                                   word_valid,
    output logic                                   overflow,
    output logic                                   symbol_err
);

    // state   | meaning
    // COLLECT | accepting symbols and letters
    // HOLD    | word presented, waiting for word_ack
    localparam int LW = 2 * MAX_SYMBOLS;
    localparam int CW = $clog2(MAX_SYMBOLS + 1);
    localparam int WW = $clog2(LETTERS + 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_n;
    logic [LW-1:0]        letter_n;
    logic [LW-1:0]        letter_a;
    logic [CW-1:0]        count_n;
    logic [CW-1:0]        count_a;
    logic [LETTERS*LW-1:0] word_n;
    logic [WW-1:0]        len_n;
    logic                 valid_n;
    logic                 ovf_n;
    logic                 serr_n;

`ifdef BACKSPACE_EN
    // A committed letter stores no count; its symbols are the non-empty pairs.
    function automatic logic [CW-1:0] sym_count(input logic [LW-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_SYMBOLS; i++) begin
            if (v[2*i +: 2] != 2'b00) n = n + CW'(1);
        end
        return n;
    endfunction
`endif

    always_comb begin
        state_n  = state;
        letter_n = letter_value;
        count_n  = letter_count;
        letter_a = letter_value;
        count_a  = letter_count;
        word_n   = word_data;
        len_n    = word_len;
        valid_n  = word_valid;
        ovf_n    = overflow;
        serr_n   = ld_dot & ld_line;

        case (state)
            ST_COLLECT: begin
`ifdef BACKSPACE_EN
                if (del_input) begin
                    if (letter_count != '0) begin
                        letter_n = letter_value >> 2;
                        count_n  = letter_count - CW'(1);
                    end else if (word_len != '0) begin
                        for (int i = 0; i < LETTERS; i++) begin
                            if (word_len == WW'(i + 1)) begin
                                letter_n             = word_data[i*LW +: LW];
                                word_n[i*LW +: LW]   = '0;
                            end
                        end
                        count_n = sym_count(letter_n);
                        len_n   = word_len - WW'(1);
                    end
                end else begin
`else
                begin
`endif
                    if (ld_dot ^ ld_line) begin
                        if (letter_count == CW'(MAX_SYMBOLS)) begin
                            ovf_n = 1'b1;
                        end else begin
                            letter_a = {letter_value[LW-3:0], ld_line, 1'b1};
                            count_a  = letter_count + CW'(1);
                        end
                    end
                    letter_n = letter_a;
                    count_n  = count_a;

                    // done_input implies a commit, so next_input alongside it adds nothing.
                    if (next_input || done_input) begin
                        if (count_a != '0) begin
                            if (word_len < WW'(LETTERS)) begin
                                for (int i = 0; i < LETTERS; i++) begin
                                    if (word_len == WW'(i)) word_n[i*LW +: LW] = letter_a;
                                end
                                len_n = word_len + WW'(1);
                            end else begin
                                ovf_n = 1'b1;
                            end
                            letter_n = '0;
                            count_n  = '0;
                        end
                    end

                    if (done_input && (len_n != '0)) begin
                        state_n = ST_HOLD;
                        valid_n = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (word_ack) begin
                    state_n  = ST_COLLECT;
                    letter_n = '0;
                    count_n  = '0;
                    word_n   = '0;
                    len_n    = '0;
                    valid_n  = 1'b0;
                    ovf_n    = 1'b0;
                end
            end
            default: state_n = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_COLLECT;
            letter_value <= '0;
            letter_count <= '0;
            word_data    <= '0;
            word_len     <= '0;
            word_valid   <= 1'b0;
            overflow     <= 1'b0;
            symbol_err   <= 1'b0;
        end else begin
            state        <= state_n;
            letter_value <= letter_n;
            letter_count <= count_n;
            word_data    <= word_n;
            word_len     <= len_n;
            word_valid   <= valid_n;
            overflow     <= ovf_n;
            symbol_err   <= serr_n;
        end
    end

endmodule

// File: tb/tb_morse_word_buffer.sv
// Bench for morse_word_buffer: directed walk-through plus random strobes against a queue-based model.
module tb_morse_word_buffer;
    localparam int MS = 5;
    localparam int L  = 4;
    localparam int LW = 2 * MS;

    logic            clock;
    logic            reset;
    logic            ld_dot;
    logic            ld_line;
    logic            next_input;
    logic            done_input;
`ifdef BACKSPACE_EN
    logic            del_input;
`endif
    logic            word_ack;
    logic [LW-1:0]   letter_value;
    logic [2:0]      letter_count;
    logic [L*LW-1:0] word_data;
    logic [2:0]      word_len;
    logic            word_valid;
    logic            overflow;
    logic            symbol_err;

    morse_word_buffer #(.MAX_SYMBOLS(MS), .LETTERS(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .ld_dot       (ld_dot),
        .ld_line      (ld_line),
        .next_input   (next_input),
        .done_input   (done_input),
`ifdef BACKSPACE_EN
        .del_input    (del_input),
`endif
        .word_ack     (word_ack),
        .letter_value (letter_value),
        .letter_count (letter_count),
        .word_data    (word_data),
        .word_len     (word_len),
        .word_valid   (word_valid),
        .overflow     (overflow),
        .symbol_err   (symbol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a letter is a list of symbol codes (oldest first), a word is a list of letters.
    logic [1:0]    m_letter[$];
    logic [LW-1:0] m_word[$];
    int            m_wcnt[$];
    bit            m_hold, m_ovf, m_serr;

    function automatic logic [LW-1:0] pack_letter();
        logic [LW-1:0] v = '0;
        foreach (m_letter[i]) v = (v << 2) | LW'(m_letter[i]);
        return v;
    endfunction

    function automatic logic [L*LW-1:0] pack_word();
        logic [L*LW-1:0] w = '0;
        foreach (m_word[i]) w[i*LW +: LW] = m_word[i];
        return w;
    endfunction

    task automatic model_step(input bit d, input bit l, input bit n, input bit dn,
                              input bit a, input bit dl, input bit r);
        if (r) begin
            m_letter.delete(); m_word.delete(); m_wcnt.delete();
            m_hold = 0; m_ovf = 0; m_serr = 0;
            return;
        end
        m_serr = d && l;
        if (m_hold) begin
            if (a) begin
                m_letter.delete(); m_word.delete(); m_wcnt.delete();
                m_hold = 0; m_ovf = 0;
            end
        end else if (dl) begin
            if (m_letter.size() > 0) begin
                void'(m_letter.pop_back());
            end else if (m_word.size() > 0) begin
                logic [LW-1:0] v = m_word.pop_back();
                int c = m_wcnt.pop_back();
                for (int i = c - 1; i >= 0; i--) m_letter.push_back(v[2*i +: 2]);
            end
        end else begin
            if (d != l) begin
                if (m_letter.size() == MS) m_ovf = 1;
                else m_letter.push_back(l ? 2'b11 : 2'b01);
            end
            if ((n || dn) && m_letter.size() > 0) begin
                if (m_word.size() < L) begin
                    m_word.push_back(pack_letter());
                    m_wcnt.push_back(m_letter.size());
                end else begin
                    m_ovf = 1;
                end
                m_letter.delete();
            end
            if (dn && m_word.size() > 0) m_hold = 1;
        end
    endtask

    task automatic step(input bit d, input bit l, input bit n, input bit dn,
                        input bit a, input bit dl, input bit r);
        ld_dot = d; ld_line = l; next_input = n; done_input = dn;
        word_ack = a; reset = r;
`ifdef BACKSPACE_EN
        del_input = dl;
`endif
        @(posedge clock);
        model_step(d, l, n, dn, a, dl, r);
        #1;
        check("letter_value", 64'(letter_value), 64'(pack_letter()));
        check("letter_count", 64'(letter_count), 64'(m_letter.size()));
        check("word_data",    64'(word_data),    64'(pack_word()));
        check("word_len",     64'(word_len),     64'(m_word.size()));
        check("word_valid",   64'(word_valid),   64'(m_hold));
        check("overflow",     64'(overflow),     64'(m_ovf));
        check("symbol_err",   64'(symbol_err),   64'(m_serr));
    endtask

    task automatic dot();   step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic line();  step(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic nxt();   step(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic done();  step(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic rst();   step(0, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        ld_dot = 0; ld_line = 0; next_input = 0; done_input = 0; word_ack = 0; reset = 1;
`ifdef BACKSPACE_EN
        del_input = 0;
`endif
        rst();
        check("rst_letter", 64'(letter_value), 64'h0);
        check("rst_valid",  64'(word_valid),   64'h0);

        repeat (3) dot();
        check("tp_s_value", 64'(letter_value), 64'h015);
        check("tp_s_count", 64'(letter_count), 64'd3);
        check("tp_s_ovf",   64'(overflow),     64'd0);

        nxt(); repeat (3) line(); nxt(); repeat (3) dot(); done();
        check("tp_sos_valid", 64'(word_valid),       64'd1);
        check("tp_sos_len",   64'(word_len),         64'd3);
        check("tp_sos_data",  64'(word_data[29:0]),  64'h0150FC15);
        check("tp_sos_upper", 64'(word_data[39:30]), 64'h0);
        check("tp_sos_count", 64'(letter_count),     64'd0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("tp_ack_valid", 64'(word_valid), 64'd0);
        check("tp_ack_data",  64'(word_data),  64'h0);

        repeat (6) dot();
        check("tp_ovf_value", 64'(letter_value), 64'h155);
        check("tp_ovf_count", 64'(letter_count), 64'd5);
        check("tp_ovf_flag",  64'(overflow),     64'd1);
        nxt();
        repeat (5) begin dot(); nxt(); end
        check("tp_full_len", 64'(word_len), 64'd4);
        check("tp_full_ovf", 64'(overflow), 64'd1);

        done();
        dot(); nxt(); done(); line();
        step(1, 1, 0, 0, 0, 0, 0);
        check("tp_hold_serr", 64'(symbol_err), 64'd1);
        check("tp_hold_len",  64'(word_len),   64'd4);
        rst();
        check("tp_rst_hold", 64'(word_valid), 64'd0);

        dot();
        step(1, 1, 0, 0, 0, 0, 0);
        check("tp_serr",      64'(symbol_err),   64'd1);
        check("tp_serr_keep", 64'(letter_value), 64'h001);
        nxt();
        check("tp_serr_clr",  64'(symbol_err),   64'd0);
        rst();
        step(0, 1, 1, 0, 0, 0, 0);
        check("tp_line_next_slot", 64'(word_data[9:0]), 64'h003);
        check("tp_line_next_len",  64'(word_len),       64'd1);

`ifdef BACKSPACE_EN
        rst();
        dot(); line();
        check("tp_bs_pre", 64'(letter_value), 64'h007);
        step(0, 0, 0, 0, 0, 1, 0);
        check("tp_bs_val", 64'(letter_value), 64'h001);
        check("tp_bs_cnt", 64'(letter_count), 64'd1);
        nxt();
        step(0, 0, 0, 0, 0, 1, 0);
        check("tp_pop_val", 64'(letter_value), 64'h001);
        check("tp_pop_len", 64'(word_len),     64'd0);
`endif

        for (int k = 0; k < 4000; k++) begin
            bit d, l, n, dn, a, dl, r;
            d  = ($urandom_range(99) < 35);
            l  = ($urandom_range(99) < 30);
            n  = ($urandom_range(99) < 18);
            dn = ($urandom_range(99) < 6);
            a  = ($urandom_range(99) < 20);
            r  = ($urandom_range(999) < 8);
`ifdef BACKSPACE_EN
            dl = ($urandom_range(99) < 10);
`else
            dl = 0;
`endif
            step(d, l, n, dn, a, dl, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_word_buffer.md
Name: morse_word_buffer

Overview:
- Parametrised successor to the single-player morse accumulator.
- Collects dot/line strobes from morse_decoder into a per-letter symbol register, commits letters into a multi-letter word buffer, and presents the finished word to the game logic with a valid/ack handshake.
- Adds symbol and letter counting, overflow detection, a hold state and a hold handshake.
- One instance per player.

Parameters:
- MAX_SYMBOLS, 5, maximum dot/line symbols per letter; letter register is 2*MAX_SYMBOLS bits.
- LETTERS, 4, word depth in letters.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ld_dot  input  1  one-cycle strobe, append dot.
- ld_line  input  1  one-cycle strobe, append line.
- next_input  input  1  strobe, commit current letter to word.
- done_input  input  1  strobe, finish word.
- word_ack  input  1  consumer accepted word.
- letter_value  output  2*MAX_SYMBOLS  letter in progress.
- letter_count  output  $clog2(MAX_SYMBOLS+1)  symbols in letter_value.
- word_data  output  LETTERS*2*MAX_SYMBOLS  committed letters; slot 0 in LSBs.
- word_len  output  $clog2(LETTERS+1)  committed letters.
- word_valid  output  1  word complete, held until ack.
- overflow  output  1  sticky: a symbol or letter was dropped.
- symbol_err  output  1  one-cycle pulse: ld_dot and ld_line were both high.

Behaviour:
- Reset (sampled on posedge clock while reset=1): all outputs 0; state COLLECT. Reset overrides every other input and aborts HOLD.
- Symbol encoding: dot=2'b01, line=2'b11, empty=2'b00.
  - Append: letter_value <= {letter_value[2*MAX_SYMBOLS-3:0], code}; letter_count+1.
  - Newest symbol sits in the LSBs. Result is visible the cycle after the strobe.
- States: COLLECT, HOLD.
- COLLECT:
  - ld_dot and ld_line both high: neither appended; symbol_err=1 for one cycle.
  - Strobe with letter_count==MAX_SYMBOLS: symbol dropped, overflow<=1.
  - next_input with letter_count>0 and word_len<LETTERS: word slot[word_len] <= letter (including any symbol strobed the same cycle); word_len+1; letter_value and letter_count cleared.
  - next_input with an empty letter (after same-cycle append): no-op.
  - next_input with word_len==LETTERS: letter discarded and cleared, overflow<=1.
  - done_input: performs the next_input commit first (same rules).
    - If the resulting word_len>0: go to HOLD; word_valid=1 next cycle.
    - If the word is still empty: ignored, stays in COLLECT.
  - next_input and done_input in the same cycle: treated as done_input alone (single commit).
- HOLD:
  - word_valid=1; word_data and word_len frozen.
  - ld_dot, ld_line, next_input and done_input ignored; symbol_err still reports double strobes.
  - word_ack: next cycle letter_value, letter_count, word_data, word_len, word_valid and overflow all 0; state COLLECT.
  - word_ack in COLLECT: ignored.
- Arithmetic: counters saturate; they never wrap. Unused word slots read 0.

Optional Feature:
- Macro BACKSPACE_EN.
- When defined:
  - Adds input port del_input (1 bit).
  - In COLLECT with letter_count>0: letter_value <= letter_value>>2; letter_count-1.
  - If the letter is empty and word_len>0: last committed slot is popped back into letter_value/letter_count, that slot is cleared, word_len-1.
  - del_input has priority over same-cycle ld_dot/ld_line/next_input/done_input, which are ignored that cycle. Ignored in HOLD.
- When undefined: port absent; no delete logic.

Test Plan:
- MAX_SYMBOLS=5, LETTERS=4 throughout.
- Reset, then ld_dot ×3 -> letter_value=10'h015, letter_count=3, word_valid=0, overflow=0.
- S,next,O(line ×3),next,S,done -> word_valid=1 one cycle after done; word_len=3; word_data[29:0]=30'h0150FC15; upper slot 0; letter_count=0. Then word_ack -> next cycle all outputs 0, state COLLECT.
- ld_dot ×6 -> letter_value=10'h155, letter_count=5, overflow=1. Five single-dot letters each committed with next -> word_len=4; fifth commit discarded; overflow stays 1.
- ld_dot and ld_line high together -> symbol_err=1 for one cycle, letter unchanged. ld_line with next_input same cycle on an empty letter -> slot0=10'h003, word_len=1.
- In HOLD, pulse ld_dot, next_input, done_input -> word_data/word_len unchanged. Assert reset mid-HOLD -> all outputs 0 next cycle.
- BACKSPACE_EN: dot,line (10'h007), del -> 10'h001, count 1. Commit, then del on empty letter -> letter_value=10'h001, word_len=0.
